synkey: RTL and testbench

Keypad front end that feeds the central FSM. It synchronises 16 asynchronous key lines and debounces them, then priority-encodes the result. For each accepted press it emits a one-cycle `pressed` strobe together with the 4-bit key code on `buttonBus`. It is the only source of `buttonBus`/`pressed` in the design, and it guarantees that at most one key event reaches the FSM per cycle.

---
 rtl/synkey.sv | 135 +++++++++++++
 tb/tb_synkey.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/synkey.sv
// Keypad front end: 2-flop synchroniser, debounce FSM and priority encoder for 16 key lines.
// Optional held-key auto-repeat is built when SYNKEY_REPEAT_EN is defined.
module synkey #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] keys,
    output logic [3:0]  buttonBus,
    output logic        pressed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("synkey: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("synkey: REPEAT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [3:0]     cand;
    logic [15:0]    sync1;
    logic [15:0]    s;
    logic [3:0]     enc;
    logic           any;

`ifdef SYNKEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0]  rcnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= keys;
            s     <= sync1;
        end
    end

    // Ascending scan so the highest set bit wins.
    always_comb begin
        enc = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (s[i]) enc = 4'(i);
        end
    end

    assign any = |s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            pressed   <= 1'b0;
            buttonBus <= 4'h0;
`ifdef SYNKEY_REPEAT_EN
            rcnt      <= '0;
`endif
        end else begin
            pressed   <= 1'b0;
            buttonBus <= 4'h0;
            case (state)
                IDLE: begin
                    if (any) begin
                        cand  <= enc;
                        cnt   <= '0;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!any || enc != cand) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= HELD;
                        pressed   <= 1'b1;
                        buttonBus <= cand;
`ifdef SYNKEY_REPEAT_EN
                        rcnt      <= '0;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (!any) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end
`ifdef SYNKEY_REPEAT_EN
                    // Repeat counter freezes while a different key dominates.
                    else if (enc == cand) begin
                        if (rcnt == RCNT_LAST) begin
                            pressed   <= 1'b1;
                            buttonBus <= cand;
                            rcnt      <= '0;
                        end else begin
                            rcnt <= rcnt + RW'(1);
                        end
                    end
`endif
                end
                RELEASE: begin
                    if (any) begin
                        state <= HELD;
`ifdef SYNKEY_REPEAT_EN
                        rcnt  <= '0;
`endif
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_synkey.sv
// Bench for synkey: table of single presses plus hand-built bounce, key-change and reset sequences.
// Expected strobes (cycle, code) are queued when keys are driven and matched as pressed fires.
module tb_synkey;

    localparam int unsigned D = 4;
    localparam int unsigned R = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] keys;
    logic [3:0]  buttonBus;
    logic        pressed;

    synkey #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .keys     (keys),
        .buttonBus(buttonBus),
        .pressed  (pressed)
    );

    typedef struct {
        int unsigned cyc;
        logic [3:0]  code;
    } exp_t;

    typedef struct {
        logic [15:0] keys;
        int unsigned hold;
        logic [3:0]  code;
    } vec_t;

    exp_t        sb[$];
    exp_t        got;
    vec_t        vecs[8];
    int unsigned cyc;
    int unsigned passed;
    int unsigned total;
    int unsigned c0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Clean press driven at negedge c and held for h cycles.
    task automatic push_press(input int unsigned c, input int unsigned h, input logic [3:0] code);
        if (h >= D + 1) begin
            sb.push_back('{c + 3 + D, code});
`ifdef SYNKEY_REPEAT_EN
            for (int unsigned k = 1; c + 3 + D + R * k <= c + h + 2; k++)
                sb.push_back('{c + 3 + D + R * k, code});
`endif
        end
    endtask

    task automatic settle_and_drain(input string name);
        keys = '0;
        repeat (D + 8) @(negedge clk);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (pressed) begin
            if (sb.size() > 0) begin
                got = sb.pop_front();
                check("strobe_cycle", cyc, got.cyc);
                check("strobe_code", buttonBus, got.code);
            end else begin
                check("spurious_strobe", pressed, 0);
            end
        end else begin
            check("bus_idle", buttonBus, 0);
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                check("strobe_missing", pressed, 1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        vecs[0] = '{16'h0800, 20, 4'hB};
        vecs[1] = '{16'h0008,  2, 4'h3};
        vecs[2] = '{16'h8201, 10, 4'hF};
        vecs[3] = '{16'h0001,  6, 4'h0};
        vecs[4] = '{16'hFFFF,  8, 4'hF};
        vecs[5] = '{16'h0020,  5, 4'h5};
        vecs[6] = '{16'h0040,  4, 4'h6};
        vecs[7] = '{16'h4000, 40, 4'hE};

        cyc    = 0;
        passed = 0;
        total  = 0;
        keys   = '0;
        rst_n  = 1'b0;
        #1;
        check("reset_pressed", pressed, 0);
        check("reset_bus", buttonBus, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int unsigned i = 0; i < 8; i++) begin
            c0   = cyc;
            keys = vecs[i].keys;
            push_press(c0, vecs[i].hold, vecs[i].code);
            repeat (vecs[i].hold) @(negedge clk);
            settle_and_drain("vec_drain");
        end

        // Extra key 0xC joins while ENTER is held; ENTER stays the highest code.
        c0   = cyc;
        keys = 16'h8201;
        push_press(c0, 20, 4'hF);
        repeat (10) @(negedge clk);
        keys = 16'h9201;
        repeat (10) @(negedge clk);
        settle_and_drain("add_key_drain");

        // A different key taking over while held never strobes and freezes repeat.
        c0   = cyc;
        keys = 16'h0008;
        sb.push_back('{c0 + 3 + D, 4'h3});
        repeat (10) @(negedge clk);
        keys = 16'h0408;
        repeat (10) @(negedge clk);
        settle_and_drain("key_change_drain");

        // Bouncing release, then a second key.
        c0   = cyc;
        keys = 16'h0020;
        push_press(c0, 10, 4'h5);
        repeat (10) @(negedge clk);
        for (int unsigned b = 0; b < 6; b++) begin
            keys = (b % 2 == 1) ? 16'h0020 : 16'h0000;
            @(negedge clk);
        end
        keys = '0;
        repeat (12) @(negedge clk);
        c0   = cyc;
        keys = 16'h0080;
        push_press(c0, 10, 4'h7);
        repeat (10) @(negedge clk);
        settle_and_drain("bounce_drain");

        // Reset two cycles into DEBOUNCE, key still held afterwards.
        keys = 16'h0400;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_pressed", pressed, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        c0    = cyc;
        push_press(c0, 15, 4'hA);
        repeat (15) @(negedge clk);
        settle_and_drain("reset_drain");

        // Reset clears an active strobe without waiting for a clock edge.
        c0   = cyc;
        keys = 16'h0002;
        repeat (3 + D) @(posedge clk);
        #1;
        check("pre_reset_strobe", pressed, 1);
        check("pre_reset_code", buttonBus, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_pressed", pressed, 0);
        check("async_reset_bus", buttonBus, 0);
        keys = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        settle_and_drain("final_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
